// File: rtl/regfile_mp_scoreboard.sv
// rtl/regfile_mp_scoreboard.sv - multi-port register file with per-register pending scoreboard
// Define REGFILE_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp_scoreboard #(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int REG_ADDR_W = $clog2(REG_COUNT),
  parameter int NUM_RD     = 2,
  parameter int NUM_WR     = 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic                               clk_en,
  input  logic [NUM_WR-1:0]                  we,
  input  logic [NUM_WR-1:0][REG_ADDR_W-1:0]  wa,
  input  logic [NUM_WR-1:0][XLEN-1:0]        wd,
  input  logic [NUM_RD-1:0][REG_ADDR_W-1:0]  ra,
  output logic [NUM_RD-1:0][XLEN-1:0]        rd,
  output logic [NUM_RD-1:0]                  rd_busy,
  input  logic                               rsv_valid,
  input  logic [REG_ADDR_W-1:0]              rsv_addr,
  output logic                               rsv_stall,
  output logic [REG_COUNT-1:0]               pending
);

  logic [XLEN-1:0] regs [REG_COUNT];
  logic            rsv_released;
  logic            rsv_accept;

  // A writeback retiring the same register lets a new producer claim it this cycle.
  always_comb begin
    rsv_released = 1'b0;
    for (int k = 0; k < NUM_WR; k++) begin
      if (clk_en && we[k] && (wa[k] == rsv_addr)) rsv_released = 1'b1;
    end
  end

  assign rsv_stall  = rsv_valid && (rsv_addr != '0) && pending[rsv_addr] && !rsv_released;
  assign rsv_accept = clk_en && rsv_valid && (rsv_addr != '0) && !rsv_stall;

  // Later loop iterations override earlier ones, so the highest write port wins.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int r = 0; r < REG_COUNT; r++) regs[r] <= '0;
      pending <= '0;
    end else if (clk_en) begin
      for (int k = 0; k < NUM_WR; k++) begin
        if (we[k] && (wa[k] != '0)) begin
          regs[wa[k]]    <= wd[k];
          pending[wa[k]] <= 1'b0;
        end
      end
      if (rsv_accept) pending[rsv_addr] <= 1'b1;
    end
  end

  always_comb begin
    rd      = '0;
    rd_busy = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      if (ra[i] != '0) begin
        rd[i]      = regs[ra[i]];
        rd_busy[i] = pending[ra[i]];
`ifdef REGFILE_BYPASS_EN
        for (int k = 0; k < NUM_WR; k++) begin
          if (clk_en && we[k] && (wa[k] == ra[i])) begin
            rd[i]      = wd[k];
            rd_busy[i] = (rsv_accept && (rsv_addr == ra[i])) ? pending[ra[i]] : 1'b0;
          end
        end
`endif
      end
    end
  end

endmodule

// File: doc/regfile_mp_scoreboard.md
Name: regfile_mp_scoreboard

Overview:
- Parametrised successor to the core's single-write, dual-read register file.
- Configurable count of read ports and write ports.
- Per-register pending (scoreboard) bits: the issue stage reserves a destination, and the writeback clears it.
- Optional same-cycle write-to-read bypass.
- Sits between decode/issue (reads, reservations) and writeback (writes); feeds hazard/stall logic.

Parameters:
- XLEN, 32, data width in bits.
- REG_COUNT, 32, number of architectural registers; register 0 is hardwired zero.
- REG_ADDR_W, $clog2(REG_COUNT), register address width.
- NUM_RD, 2, number of read ports (≥1).
- NUM_WR, 1, number of write ports (≥1); a higher index has higher priority.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- rst  in  1  synchronous active-high reset.
- clk_en  in  1  state-update enable; when low, no register, pending or write state changes.
- we  in  NUM_WR  write enable per write port.
- wa  in  NUM_WR x REG_ADDR_W  write address per port.
- wd  in  NUM_WR x XLEN  write data per port.
- ra  in  NUM_RD x REG_ADDR_W  read address per port.
- rd  out  NUM_RD x XLEN  read data per port (combinational).
- rd_busy  out  NUM_RD  read port's register is pending (combinational).
- rsv_valid  in  1  reserve request from issue.
- rsv_addr  in  REG_ADDR_W  register to mark pending.
- rsv_stall  out  1  reservation refused this cycle (combinational).
- pending  out  REG_COUNT  registered scoreboard vector.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at posedge, regardless of clk_en):
  - All registers clear to 0.
  - pending clears to 0.
  - rd and rd_busy then reflect zeroed state.
- Writes: at posedge with clk_en=1, every port with we[k]=1 and wa[k]≠0 writes wd[k] into regs[wa[k]].
  - Two or more ports target the same address: highest-index port's data is stored.
  - Writes to address 0 are discarded.
- Release: any accepted write (we[k]=1, wa[k]≠0, clk_en=1) clears pending[wa[k]] at the same edge.
- Reservation: rsv_valid=1, rsv_addr≠0, rsv_stall=0, clk_en=1 sets pending[rsv_addr] at posedge.
  - rsv_addr=0 is accepted as a no-op; pending[0] is always 0.
- rsv_stall = rsv_valid && rsv_addr≠0 && pending[rsv_addr] && no write port releasing rsv_addr this cycle.
  - This is a single-outstanding-producer model; a refused reservation changes nothing.
- Same-cycle release and reservation of one address: reservation wins; pending stays 1.
- Reads: combinational.
  - Without bypass: rd[i] = regs[ra[i]] and rd_busy[i] = pending[ra[i]].
  - ra[i]=0 always gives rd=0 and rd_busy=0.
- clk_en=0: writes, releases and reservations are ignored; rsv_stall and reads remain live.
- Latency:
  - Write is visible on rd one cycle after the write edge without bypass; zero cycles with bypass.
  - pending updates are visible one cycle after the edge.
- No internal FSM beyond the pending vector. The storage array plus the REG_COUNT pending flops form the state.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: for each read port i with ra[i]≠0, if any write port has we[k]=1 and wa[k]=ra[i] this cycle:
  - rd[i] = wd of the highest such k.
  - rd_busy[i] = 0, unless rsv_valid and rsv_addr=ra[i] are also accepted this cycle (then stays 1 from pending, i.e. pending[ra[i]] as registered).
  - Bypass is qualified by clk_en; with clk_en=0, no forwarding.
- Undefined: no forwarding paths; reads return stored values only; rd_busy = pending[ra[i]].

Test Plan:
- Reset then read: assert rst 2 cycles; ra={5,0} -> rd={0,0}, rd_busy=0, pending=0.
- Reserve/release: rsv x7 cycle 0 -> pending[7]=1 cycle 1, rd_busy=1 on ra=7.
  - Write x7=0xDEADBEEF cycle 2 -> pending[7]=0 cycle 3.
  - rd=0xDEADBEEF cycle 3, or cycle 2 with REGFILE_BYPASS_EN.
- Double reserve: x9 pending, rsv x9 again -> rsv_stall=1, pending unchanged.
  - Same cycle plus write to x9 -> rsv_stall=0, pending[9] stays 1, data stored.
- Write priority: NUM_WR=2, both ports write x3 with 0x11/0x22 -> x3=0x22 next cycle.
  - Both write x0 -> x0 reads 0.
- clk_en gating: clk_en=0 with we=1 x4=0x55 and rsv x4 -> x4 and pending[4] unchanged.
  - Same stimulus with clk_en=1 -> x4=0x55 and pending[4]=1 (the reservation wins over the release).
- Reset mid-operation: pending=0x0000_0F00 and writes in flight, rst=1 with clk_en=0 -> pending=0 and all regs 0 next cycle.
